// File: rtl/serializer_if.sv
// Parallel-word in / serial-bit out bundle for the serializer.
// The master side is the word source; the slave side is the serializer itself.
interface serializer_if #(
  parameter int DATA_W = 16
);
  localparam int MOD_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  modport master (
    output data_i,
    output data_mod_i,
    output data_val_i,
    input  ser_data_o,
    input  ser_data_val_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  data_mod_i,
    input  data_val_i,
    output ser_data_o,
    output ser_data_val_o,
    output busy_o
  );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter: shifts the top N bits of an accepted word out
// MSB first, one bit per clock, with a per-bit valid strobe.
module serializer #(
  parameter int DATA_W = 16
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  serializer_if.slave bus
);
  localparam int MOD_W = $clog2(DATA_W) + 1;
  localparam logic [MOD_W-1:0] FULL_LEN = MOD_W'(DATA_W);
  localparam logic [MOD_W-1:0] MIN_LEN  = MOD_W'(3);
  localparam logic [MOD_W-1:0] LAST_CNT = MOD_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [MOD_W-1:0]  cnt_q,   cnt_d;
  logic [MOD_W-1:0]  len;

  // Zero and out-of-range counts both mean a full-width word.
  always_comb begin
    len = bus.data_mod_i;
    if (bus.data_mod_i == '0 || bus.data_mod_i > FULL_LEN) begin
      len = FULL_LEN;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Words of one or two bits are silently discarded.
        if (bus.data_val_i && len >= MIN_LEN) begin
          state_d = SEND;
          shift_d = bus.data_i;
          cnt_d   = len;
        end
      end
      SEND: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q - LAST_CNT;
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shift register is zero whenever idle, so its MSB doubles as the idle-low data.
  assign bus.ser_data_o     = shift_q[DATA_W-1];
  assign bus.ser_data_val_o = (state_q == SEND);
  assign bus.busy_o         = (state_q == SEND);
endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter. Takes a DATA_W-bit word plus a valid-bit count and shifts the valid bits out MSB first, one bit per clock, with a per-bit valid strobe.
- Sits directly upstream of the 16-bit deserializer. Its ser_data_o / ser_data_val_o drive that stage's data_i / data_val_i, giving a serial loopback path for packing and unpacking words.

Parameters:
- DATA_W, 16, parallel word width. Must be a power of two and at least 4.
- MOD_W, $clog2(DATA_W)+1, width of data_mod_i. Derived; do not override.

Ports:
- clk_i  input  1  clock; all logic on the rising edge
- arst_n_i  input  1  asynchronous active-low reset
- data_i  input  DATA_W  parallel word; bit DATA_W-1 is sent first
- data_mod_i  input  MOD_W  number of valid bits, counted from the MSB; 0 means DATA_W
- data_val_i  input  1  word valid; qualifies data_i and data_mod_i
- ser_data_o  output  1  serial data bit
- ser_data_val_o  output  1  ser_data_o is valid this cycle
- busy_o  output  1  a transmission is in progress; new words are not accepted

Behaviour:
- Reset:
  - arst_n_i low clears all state immediately, without waiting for a clock edge: ser_data_o=0, ser_data_val_o=0, busy_o=0, bit counter=0, shift register=0.
  - Release is synchronised by the integrator; the block needs no internal reset synchroniser.
- Effective length N = (data_mod_i==0) ? DATA_W : data_mod_i. Values above DATA_W are clamped to DATA_W.
- Accept condition: data_val_i && !busy_o at a rising edge.
  - If N is 1 or 2, the word is discarded: no output, busy_o stays 0.
  - Otherwise data_i is latched into the shift register and the counter is loaded with N.
- Two states:
  - IDLE: busy_o=0, ser_data_val_o=0, ser_data_o=0.
  - SEND: busy_o=1, ser_data_val_o=1.
  - IDLE->SEND on a valid accept. SEND->IDLE on the edge after the last bit is presented.
- Latency and order:
  - For a word accepted at edge t, bit k (k=0..N-1) appears on ser_data_o during cycle t+1+k and equals data_i[DATA_W-1-k].
  - ser_data_val_o and busy_o are high for exactly N consecutive cycles, t+1..t+N.
  - All outputs are registered.
- Back-to-back: busy_o is low in cycle t+N+1, so the earliest next accept is that edge and its first bit appears in cycle t+N+2. There is one guaranteed idle cycle between words.
- data_val_i while busy_o=1 is ignored. Such a word is dropped and does not corrupt the word in flight. The source must hold or re-present it.
- data_i and data_mod_i are don't-care except at the accept edge. The block latches them, so they may change freely during SEND.
- Counter width is MOD_W. It decrements once per SEND cycle; SEND exits when the counter reaches 1 at an edge. No wrap-around is possible.
- Reset asserted mid-word: output stops immediately. After release the block is in IDLE, with no residual bits and no spurious strobe.
- Output contract for the downstream deserializer: after reset, 16 strobes from full-width words (data_mod_i=0) form exactly one aligned output word there.

Test Plan:
- Reset, then send data_i=16'hA5C3, data_mod_i=0, one-cycle data_val_i -> bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on 16 consecutive strobes starting the cycle after accept; busy_o high for exactly those 16 cycles.
- data_i=16'hF000, data_mod_i=5 -> 5 strobes carrying 1,1,1,1,0; busy_o low on the 6th cycle.
- data_mod_i=1, then data_mod_i=2, each with data_val_i -> no strobe; busy_o stays 0.
- data_val_i held high for 40 cycles, data_i=16'h8001, data_mod_i=0 -> words accepted at cycles 0, 17 and 34; each burst 1,0,...,0,1; exactly one idle cycle between bursts. A data_i change to 16'hFFFF mid-burst does not affect the bits in flight.
- Assert arst_n_i low at bit 7 of 16'hFFFF -> ser_data_val_o=0 and busy_o=0 immediately, without waiting for a clock edge; after release, a new 16'h1234 word serialises correctly from bit 15.
- Loopback into the 16-bit deserializer with random full-width words (data_mod_i=0) -> each received deser_data_o equals the sent word; one deser_data_val_o pulse per word.
